// File: rtl/chan_pkg.sv
// chan_pkg: shared definitions for the channelizer reconfiguration sequencer.
//   - chan_state_t : sequencer states (also exported on the debug port)
//   - NFFT_LSB / FWD_LSB : bit offsets inside the 16-bit FFT config word
//   - log2_pow2()  : log2 of a value plus a power-of-two flag
//   - cfg_word()   : builds the FFT config word from direction and nfft
package chan_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN  = 3'd0,
    ST_RST    = 3'd1,
    ST_FRST   = 3'd2,
    ST_CONFIG = 3'd3,
    ST_RUN    = 3'd4
  } chan_state_t;

  localparam int CFG_W    = 16;
  localparam int NFFT_LSB = 0;
  localparam int FWD_LSB  = 8;

  typedef struct packed {
    logic       pow2;
    logic [4:0] log2;
  } log2_res_t;

  // log2 is the index of the highest set bit; only meaningful when pow2=1.
  function automatic log2_res_t log2_pow2(input logic [31:0] v);
    log2_res_t r;
    r.pow2 = (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    r.log2 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r.log2 = 5'(i);
    end
    return r;
  endfunction

  function automatic logic [CFG_W-1:0] cfg_word(input logic fwd, input logic [4:0] nfft);
    logic [CFG_W-1:0] w;
    w                  = '0;
    w[FWD_LSB]         = fwd;
    w[NFFT_LSB +: 5]   = nfft;
    return w;
  endfunction

endpackage

// File: rtl/chan_size_check.sv
// chan_size_check: combinational validation of a requested FFT size.
//   size : requested FFT size (points)
//   ok   : size is a power of two with MIN_LOG2 <= log2 <= MAX_LOG2
//   log2 : log2 of size (valid when ok=1)
module chan_size_check
  import chan_pkg::*;
#(
  parameter int MAX_LOG2 = 11,
  parameter int MIN_LOG2 = 3
) (
  input  logic [MAX_LOG2:0] size,
  output logic              ok,
  output logic [4:0]        log2
);

  log2_res_t res;

  assign res  = log2_pow2(32'(size));
  assign log2 = res.log2;
  assign ok   = res.pow2 && (res.log2 >= 5'(MIN_LOG2)) && (res.log2 <= 5'(MAX_LOG2));

endmodule

// File: rtl/chan_reconfig_ctrl.sv
// chan_reconfig_ctrl: runtime FFT-size/direction reconfiguration sequencer.
// Sequence after an accepted request: DRAIN -> RST -> FRST -> CONFIG -> RUN.
// Ports:
//   s_cfg_*     : request stream {fwd_inv, fft_size}, accepted only in RUN
//   pipe_busy   : datapath activity, used to detect the drained condition
//   gate_open   : input gate, open only in RUN
//   blk_reset   : active-high datapath reset (RST state)
//   fft_aresetn : FFT core reset, low in RST and FRST
//   fft_size_o  : active FFT size
//   m_cfg_*     : FFT config word stream, valid in CONFIG
//   busy/cfg_err/drain_to/done : status
//   state       : current sequencer state (debug)
// Handshakes: a transfer happens on a rising clk edge where tvalid and tready
// are both high; m_cfg_tdata is held constant while m_cfg_tvalid is high.
module chan_reconfig_ctrl
  import chan_pkg::*;
#(
  parameter int MAX_LOG2       = 11,
  parameter int MIN_LOG2       = 3,
  parameter int DEF_LOG2       = 7,
  parameter int RESET_CYCLES   = 8,
  parameter int FFT_RST_CYCLES = 4,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_cfg_tvalid,
  input  logic [MAX_LOG2+1:0] s_cfg_tdata,
  output logic                s_cfg_tready,
  input  logic                pipe_busy,
  output logic                gate_open,
  output logic                blk_reset,
  output logic                fft_aresetn,
  output logic [MAX_LOG2:0]   fft_size_o,
  output logic                m_cfg_tvalid,
  output logic [15:0]         m_cfg_tdata,
  input  logic                m_cfg_tready,
  output logic                busy,
  output logic                cfg_err,
  output logic                drain_to,
  output logic                done,
  output chan_state_t         state
);

  localparam int CNT_MAX = (DRAIN_TIMEOUT > RESET_CYCLES) ?
                           ((DRAIN_TIMEOUT > FFT_RST_CYCLES) ? DRAIN_TIMEOUT : FFT_RST_CYCLES) :
                           ((RESET_CYCLES > FFT_RST_CYCLES) ? RESET_CYCLES : FFT_RST_CYCLES);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRST_LD  = CNT_W'(FFT_RST_CYCLES - 1);
  localparam logic [4:0]       DEF_NFFT = 5'(DEF_LOG2);
  localparam logic [MAX_LOG2:0] SIZE_ONE = {{MAX_LOG2{1'b0}}, 1'b1};

  logic              req_ok;
  logic [4:0]        req_log2;
  chan_state_t       state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              prev_idle;
  logic [4:0]        pend_log2, pend_log2_n;
  logic              pend_fwd, pend_fwd_n;
  logic              cfg_err_n, drain_to_n, done_n;
  logic              req;

  chan_size_check #(
    .MAX_LOG2 (MAX_LOG2),
    .MIN_LOG2 (MIN_LOG2)
  ) u_size_check (
    .size (s_cfg_tdata[MAX_LOG2:0]),
    .ok   (req_ok),
    .log2 (req_log2)
  );

  assign req = s_cfg_tvalid & s_cfg_tready;

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == '0) ? cnt : cnt - 1'b1;
    pend_log2_n = pend_log2;
    pend_fwd_n  = pend_fwd;
    cfg_err_n   = 1'b0;
    drain_to_n  = 1'b0;
    done_n      = 1'b0;
    case (state)
      ST_RUN: begin
        if (req) begin
          if (req_ok) begin
            pend_log2_n = req_log2;
            pend_fwd_n  = s_cfg_tdata[MAX_LOG2+1];
            state_n     = ST_DRAIN;
            cnt_n       = DRAIN_LD;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // prev_idle carries pipe_busy from the previous cycle, so the idle
        // window may include the handshake cycle itself; an idle pipe then
        // leaves DRAIN after a single cycle.
        if (prev_idle && !pipe_busy) begin
          state_n = ST_RST;
          cnt_n   = RST_LD;
        end else if (cnt == '0) begin
          drain_to_n = 1'b1;
          state_n    = ST_RST;
          cnt_n      = RST_LD;
        end
      end
      ST_RST: begin
        if (cnt == '0) begin
          state_n = ST_FRST;
          cnt_n   = FRST_LD;
        end
      end
      ST_FRST: begin
        if (cnt == '0) state_n = ST_CONFIG;
      end
      ST_CONFIG: begin
        if (m_cfg_tready) begin
          state_n = ST_RUN;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_RST;
        cnt_n   = RST_LD;
      end
    endcase
  end

  // All outputs are registered images of the next state, so none of them
  // has a combinational path from an input.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_RST;
      cnt          <= RST_LD;
      prev_idle    <= 1'b0;
      pend_log2    <= DEF_NFFT;
      pend_fwd     <= 1'b1;
      fft_size_o   <= SIZE_ONE << DEF_NFFT;
      m_cfg_tdata  <= cfg_word(1'b1, DEF_NFFT);
      s_cfg_tready <= 1'b0;
      gate_open    <= 1'b0;
      blk_reset    <= 1'b1;
      fft_aresetn  <= 1'b0;
      m_cfg_tvalid <= 1'b0;
      busy         <= 1'b1;
      cfg_err      <= 1'b0;
      drain_to     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      prev_idle    <= !pipe_busy;
      pend_log2    <= pend_log2_n;
      pend_fwd     <= pend_fwd_n;
      // The new configuration becomes active on the first RST cycle.
      if (state_n == ST_RST && state != ST_RST) begin
        fft_size_o  <= SIZE_ONE << pend_log2;
        m_cfg_tdata <= cfg_word(pend_fwd, pend_log2);
      end
      s_cfg_tready <= (state_n == ST_RUN);
      gate_open    <= (state_n == ST_RUN);
      blk_reset    <= (state_n == ST_RST);
      fft_aresetn  <= !((state_n == ST_RST) || (state_n == ST_FRST));
      m_cfg_tvalid <= (state_n == ST_CONFIG);
      busy         <= (state_n != ST_RUN);
      cfg_err      <= cfg_err_n;
      drain_to     <= drain_to_n;
      done         <= done_n;
    end
  end

endmodule
